// File: rtl/aes_block_loader.sv
// aes_block_loader: gathers eight 32-bit words (four key words, then four
// plaintext words, most-significant first) into Key/Plain_txt, issues a
// one-cycle Valid start pulse to the AES core and holds Busy until Aes_done.
// Optional feature macro: KEY_REUSE_EN adds the Key_reuse port, letting a
// block skip the key words and reuse the key already loaded.
module aes_block_loader (
    input  logic         CLK,
    input  logic         rst,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [31:0]  In_data,
    input  logic         Aes_done,
`ifdef KEY_REUSE_EN
    input  logic         Key_reuse,
`endif
    output logic         Valid,
    output logic [127:0] Key,
    output logic [127:0] Plain_txt,
    output logic         Busy
);

    typedef enum logic [1:0] {
        LOAD_KEY  = 2'd0,
        LOAD_PT   = 2'd1,
        FIRE      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t         r_state;
    logic [1:0]     r_cnt;
    logic           r_valid;
    logic           r_busy;
    logic           r_ready;
    logic [127:0]   r_key;
    logic [127:0]   r_pt;

    logic           w_accept;
    logic           w_last_word;
    logic [6:0]     w_lsb;
    logic           w_reuse;

    // A word moves only on a true handshake.
    assign w_accept    = In_valid & r_ready;
    assign w_last_word = (r_cnt == 2'd3);
    // Word k lands at bits [127-32k -: 32], i.e. LSB at (3-k)*32.
    assign w_lsb       = {~r_cnt, 5'b00000};

`ifdef KEY_REUSE_EN
    logic r_key_loaded;

    // Remembers that a full key has been loaded since the last reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_key_loaded <= 1'b0;
        end else if ((r_state == LOAD_KEY) && w_accept && w_last_word) begin
            r_key_loaded <= 1'b1;
        end
    end

    assign w_reuse = Key_reuse & r_key_loaded;
`else
    assign w_reuse = 1'b0;
`endif

    // Block-loading FSM with registered handshake and status outputs.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= LOAD_KEY;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_key   <= '0;
            r_pt    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                LOAD_KEY: begin
                    if (w_accept) begin
                        r_key[w_lsb +: 32] <= In_data;
                        r_cnt              <= r_cnt + 2'd1;
                        if (w_last_word) begin
                            r_state <= LOAD_PT;
                        end
                    end
                end
                LOAD_PT: begin
                    if (w_accept) begin
                        r_pt[w_lsb +: 32] <= In_data;
                        r_cnt             <= r_cnt + 2'd1;
                        if (w_last_word) begin
                            // Last word: Valid/Busy rise together with FIRE.
                            r_state <= FIRE;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                FIRE: begin
                    // Aes_done is deliberately ignored here.
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (Aes_done) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= w_reuse ? LOAD_PT : LOAD_KEY;
                    end
                end
                default: begin
                    r_state <= LOAD_KEY;
                    r_cnt   <= 2'd0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign In_ready  = r_ready;
    assign Valid     = r_valid;
    assign Busy      = r_busy;
    assign Key       = r_key;
    assign Plain_txt = r_pt;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader. A queue-based reference model
// predicts handshake/status outputs each cycle and the assembled Key and
// Plain_txt whenever a block has completed. Define KEY_REUSE_EN to also
// exercise the key-reuse feature.
module tb_aes_block_loader;

`ifdef KEY_REUSE_EN
    localparam bit REUSE_EN = 1'b1;
`else
    localparam bit REUSE_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         aes_done;
    logic         key_reuse;
    logic         valid;
    logic [127:0] key;
    logic [127:0] plain_txt;
    logic         busy;

    aes_block_loader dut (
        .CLK       (clk),
        .rst       (rst),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .In_data   (in_data),
        .Aes_done  (aes_done),
`ifdef KEY_REUSE_EN
        .Key_reuse (key_reuse),
`endif
        .Valid     (valid),
        .Key       (key),
        .Plain_txt (plain_txt),
        .Busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase 0 = collecting words, 1 = start pulse, 2 = core busy.
    int           m_ph    = 0;
    int           m_need  = 8;
    bit           m_kl    = 1'b0;
    bit           m_known = 1'b0;
    logic [31:0]  q[$];
    logic [127:0] exp_key = '0;
    logic [127:0] exp_pt  = '0;

    logic [31:0] vec [8];
    localparam logic [127:0] REF_KEY = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] REF_PT  = 128'h0123456789abcdeffedcba9876543210;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            q.delete();
            m_ph    = 0;
            m_need  = 8;
            m_kl    = 1'b0;
            exp_key = '0;
            exp_pt  = '0;
            m_known = 1'b1;
        end else if (m_ph == 1) begin
            m_ph = 2;
        end else if (m_ph == 2) begin
            if (aes_done) begin
                m_ph   = 0;
                m_need = (REUSE_EN && key_reuse && m_kl) ? 4 : 8;
            end
        end else if (in_valid) begin
            if (q.size() == 0) m_known = 1'b0;
            q.push_back(in_data);
            if (m_need == 8 && q.size() == 4) m_kl = 1'b1;
            if (q.size() == m_need) begin
                if (m_need == 8) begin
                    exp_key = {q[0], q[1], q[2], q[3]};
                    exp_pt  = {q[4], q[5], q[6], q[7]};
                end else begin
                    exp_pt  = {q[0], q[1], q[2], q[3]};
                end
                q.delete();
                m_ph    = 1;
                m_known = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, (m_ph == 0));
        chk("valid",    valid,    (m_ph == 1));
        chk("busy",     busy,     (m_ph != 0));
        if (m_known) begin
            chk("key",       key,       exp_key);
            chk("plain_txt", plain_txt, exp_pt);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic dn,
                        input logic r, input logic ku);
        in_valid  = v;
        in_data   = d;
        aes_done  = dn;
        rst       = r;
        key_reuse = ku;
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    // Sends the reference vector; gap>0 idles that many cycles after words 2 and 6.
    task automatic send_vec(input int gap);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vec[i], 1'b0, 1'b0, 1'b0);
            if ((i == 1 || i == 5) && gap > 0) begin
                for (int g = 0; g < gap; g++) step(1'b0, 32'hdeadbeef, 1'b0, 1'b0, 1'b0);
            end
        end
        chk("ref_valid", valid, 1'b1);
        chk("ref_key",   key,   REF_KEY);
        chk("ref_pt",    plain_txt, REF_PT);
    endtask

    initial begin
        vec[0] = 32'h0f1571c9; vec[1] = 32'h47d9e859; vec[2] = 32'h0cb7add6; vec[3] = 32'haf7f6798;
        vec[4] = 32'h01234567; vec[5] = 32'h89abcdef; vec[6] = 32'hfedcba98; vec[7] = 32'h76543210;
        in_valid = 1'b0; in_data = '0; aes_done = 1'b0; rst = 1'b1; key_reuse = 1'b0;

        // Reset state
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Back-to-back block, then wait with Busy high
        send_vec(0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("wait_valid_low", valid, 1'b0);

        // Words offered while waiting are refused; Aes_done releases the loader
        for (int i = 0; i < 10; i++) step(1'b1, 32'hffffffff, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("done_ready", in_ready, 1'b1);
        chk("done_busy",  busy,     1'b0);
        chk("done_key",   key,      REF_KEY);
        chk("done_pt",    plain_txt, REF_PT);

        // Same block with stalls after words 2 and 6
        send_vec(3);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Aes_done pulses while loading are ignored
        for (int i = 0; i < 6; i++) step(1'b1, vec[i], 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, vec[6], 1'b1, 1'b0, 1'b0);
        step(1'b1, vec[7], 1'b0, 1'b0, 1'b0);
        chk("ld_done_key", key, REF_KEY);
        chk("ld_done_pt",  plain_txt, REF_PT);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset after 5 words discards the partial block
        for (int i = 0; i < 5; i++) step(1'b1, 32'ha5a50000 + i, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0);
        chk("rst_key", key, 128'h0);
        send_vec(0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Key reuse: only four plaintext words expected when the feature is built in
        for (int i = 0; i < 4; i++) step(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
`ifdef KEY_REUSE_EN
        chk("reuse_valid", valid, 1'b1);
        chk("reuse_key",   key, REF_KEY);
        chk("reuse_pt",    plain_txt, 128'h0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 63) == 0), $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state updates on rising CLK.
REQ-002 CLK  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 In_valid  input  1  upstream word valid.
REQ-005 In_ready  output  1  loader can accept a word this cycle.
REQ-006 In_data  input  32  key/plaintext word, most-significant word first.
REQ-007 Aes_done  input  1  Done from downstream AES_128bits core.
REQ-008 Valid  output  1  one-cycle start pulse to AES_128bits core.
REQ-009 Key  output  128  assembled key to core.
REQ-010 Plain_txt  output  128  assembled plaintext to core.
REQ-011 Busy  output  1  high from Valid pulse until Aes_done is seen.
REQ-012 Key_reuse  input  1  skip key load for next block (present only with KEY_REUSE_EN).

Function
REQ-013 FSM states SHALL be LOAD_KEY, LOAD_PT, FIRE, WAIT_DONE, with a 2-bit word counter cnt.
REQ-014 Word accepted only when In_valid=1 and In_ready=1 in the same cycle.
REQ-015 In_ready=1 in LOAD_KEY and LOAD_PT; 0 in FIRE and WAIT_DONE.
REQ-016 LOAD_KEY: accepted word cnt=k writes Key[127-32k -: 32]; cnt increments; on 4th word cnt wraps to 0 and state goes to LOAD_PT.
REQ-017 LOAD_PT: same placement into Plain_txt; on 4th word cnt wraps to 0 and state goes to FIRE.
REQ-018 FIRE: Valid=1 for exactly this one cycle, Busy=1; next state WAIT_DONE unconditionally.
REQ-019 Valid SHALL never be 1 outside FIRE; latency from 8th accepted word to Valid is exactly 1 cycle.
REQ-020 WAIT_DONE: Busy=1; on Aes_done=1 go to LOAD_KEY (or LOAD_PT per REQ-029), Busy falls next cycle.
REQ-021 Aes_done=1 in LOAD_KEY, LOAD_PT or FIRE SHALL be ignored.
REQ-022 Key and Plain_txt SHALL stay stable from FIRE until the first word of the next block is accepted.
REQ-023 In_valid=0 mid-block: loader holds state and cnt indefinitely; no partial block fires.

Reset
REQ-024 On rst=1 at a rising edge: state=LOAD_KEY, cnt=0, Valid=0, Busy=0, In_ready=1 (following cycle), Key=0, Plain_txt=0, key-loaded flag=0.
REQ-025 rst mid-block or in WAIT_DONE SHALL discard partial data; a later Aes_done from the core is ignored unless in WAIT_DONE.
REQ-026 rst has priority over any simultaneous handshake or Aes_done.

Configuration
REQ-027 Macro KEY_REUSE_EN SHALL compile in the key-reuse feature and the Key_reuse port.
REQ-028 With KEY_REUSE_EN: key-loaded flag set when 4th key word accepted, cleared only by rst.
REQ-029 With KEY_REUSE_EN: on Aes_done in WAIT_DONE, if Key_reuse=1 and key-loaded flag=1 next state is LOAD_PT, Key unchanged; else LOAD_KEY.
REQ-030 Without KEY_REUSE_EN: no Key_reuse port; every block is 8 words, WAIT_DONE always returns to LOAD_KEY.

Verification
REQ-031 Release rst, stream 0f1571c9,47d9e859,0cb7add6,af7f6798,01234567,89abcdef,fedcba98,76543210 back-to-back -> next cycle Valid=1 once, Key=0f1571c947d9e8590cb7add6af7f6798, Plain_txt=0123456789abcdeffedcba9876543210, Busy=1, In_ready=0.
REQ-032 Same stream with In_valid dropped 3 cycles after words 2 and 6 -> identical outputs, Valid 1 cycle after 8th word, never earlier.
REQ-033 In WAIT_DONE drive In_valid=1 with ffffffff for 10 cycles, then Aes_done=1 -> no word accepted, Key/Plain_txt unchanged, In_ready=1 and Busy=0 one cycle after Aes_done.
REQ-034 Assert rst after 5 accepted words, then send full 8-word vector -> Valid once, outputs equal REQ-031 values with no residue from aborted block.
REQ-035 KEY_REUSE_EN: after REQ-031 block, Key_reuse=1 with Aes_done, send 4 words 00000000 x4 -> Valid after 4th word, Key unchanged 0f1571c9..., Plain_txt=0.
REQ-036 Aes_done pulse during LOAD_PT -> ignored, state and cnt unchanged, block completes normally.
